// File: rtl/scc_pkg.sv
// Shared definitions for the core pipeline: ALU opcodes, CPSR bit positions and
// the writeback skid-buffer entry layout.
package scc_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam int unsigned CPSR_N = 31;
  localparam int unsigned CPSR_Z = 30;
  localparam int unsigned CPSR_C = 29;
  localparam int unsigned CPSR_V = 28;

  typedef struct packed {
    logic [32:0] result;   // bit 32 is the ALU carry-out
    logic        op1_msb;
    logic        op2_msb;
    logic [2:0]  oc;
    logic [3:0]  rd;
    logic        we;
    logic        sf;
  } wb_entry_t;

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry in-order FIFO of writeback entries. Exposes the head and the entry
// behind it so the stage can forward both.
module wb_skid_buf
  import scc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  wb_entry_t  push_data_i,
  input  logic       pop_i,
  output wb_entry_t  head_o,
  output logic       head_valid_o,
  output wb_entry_t  tail_o,
  output logic       tail_valid_o,
  output logic [1:0] count_o
);

  wb_entry_t  mem_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + 2'd1;
    end else if (!push_i && pop_i) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign head_valid_o = (count_q != 2'd0);
  // The second entry only exists as a distinct entry when both slots are full.
  assign tail_o       = mem_q[~rd_ptr_q];
  assign tail_valid_o = (count_q == 2'd2);
  assign count_o      = count_q;

  count_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(count_q) <= DEPTH);
  no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && 32'(count_q) == DEPTH));
  no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && count_q == 2'd0));

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: skid-buffers ALU results, retires them in order to the
// register-file write port and commits CPSR flags. WB_BYPASS_EN adds forwarding outputs.
module wb_stage
  import scc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:0] in_result,
  input  logic        in_op1_msb,
  input  logic        in_op2_msb,
  input  logic [2:0]  in_alu_oc,
  input  logic [3:0]  in_rd,
  input  logic        in_rd_we,
  input  logic        in_set_flags,
  output logic        rf_wr_en,
  output logic [3:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  input  logic        rf_wr_ready,
`ifdef WB_BYPASS_EN
  output logic        fwd0_valid,
  output logic [3:0]  fwd0_rd,
  output logic [31:0] fwd0_data,
  output logic        fwd1_valid,
  output logic [3:0]  fwd1_rd,
  output logic [31:0] fwd1_data,
`endif
  output logic [31:0] cpsr
);

  wb_entry_t   in_entry, head, tail;
  logic        head_valid, tail_valid, push, retire;
  logic [1:0]  count;
  logic [31:0] cpsr_q, cpsr_d;

  assign in_entry = '{result:  in_result,
                      op1_msb: in_op1_msb,
                      op2_msb: in_op2_msb,
                      oc:      in_alu_oc,
                      rd:      in_rd,
                      we:      in_rd_we,
                      sf:      in_set_flags};

  assign in_ready = (count != 2'd2);
  assign push     = in_valid && in_ready;
  assign retire   = head_valid && (!head.we || rf_wr_ready);

  wb_skid_buf #(
    .DEPTH (DEPTH)
  ) u_skid_buf (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .push_i       (push),
    .push_data_i  (in_entry),
    .pop_i        (retire),
    .head_o       (head),
    .head_valid_o (head_valid),
    .tail_o       (tail),
    .tail_valid_o (tail_valid),
    .count_o      (count)
  );

  assign rf_wr_en   = head_valid && head.we;
  assign rf_wr_addr = head.rd;
  assign rf_wr_data = head.result[31:0];

  // C and V are only defined for add/sub; other opcodes leave them untouched.
  always_comb begin
    cpsr_d = cpsr_q;
    if (retire && head.sf) begin
      cpsr_d[CPSR_N] = head.result[31];
      cpsr_d[CPSR_Z] = (head.result[31:0] == 32'd0);
      if (head.oc == ALU_ADD) begin
        cpsr_d[CPSR_C] = head.result[32];
        cpsr_d[CPSR_V] = (head.op1_msb == head.op2_msb) && (head.result[31] != head.op1_msb);
      end else if (head.oc == ALU_SUB) begin
        cpsr_d[CPSR_C] = head.result[32];
        cpsr_d[CPSR_V] = (head.op1_msb != head.op2_msb) && (head.result[31] != head.op1_msb);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpsr_q <= 32'd0;
    end else begin
      cpsr_q <= cpsr_d;
    end
  end

  assign cpsr = cpsr_q;

`ifdef WB_BYPASS_EN
  assign fwd0_valid = head_valid && head.we;
  assign fwd0_rd    = head.rd;
  assign fwd0_data  = head.result[31:0];
  assign fwd1_valid = tail_valid && tail.we;
  assign fwd1_rd    = tail.rd;
  assign fwd1_data  = tail.result[31:0];
`else
  logic unused_tail;
  assign unused_tail = ^{tail, tail_valid};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: accepted entries are queued with their expected
// writes, and the head of the queue is compared with the write port every cycle.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] in_result = '0;
  logic        in_op1_msb = 1'b0, in_op2_msb = 1'b0;
  logic [2:0]  in_alu_oc = '0;
  logic [3:0]  in_rd = '0;
  logic        in_rd_we = 1'b0, in_set_flags = 1'b0;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        rf_wr_ready = 1'b1;
  logic [31:0] cpsr;
`ifdef WB_BYPASS_EN
  logic        fwd0_valid, fwd1_valid;
  logic [3:0]  fwd0_rd, fwd1_rd;
  logic [31:0] fwd0_data, fwd1_data;
`endif

  always #5 clk = ~clk;

  wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_op1_msb   (in_op1_msb),
    .in_op2_msb   (in_op2_msb),
    .in_alu_oc    (in_alu_oc),
    .in_rd        (in_rd),
    .in_rd_we     (in_rd_we),
    .in_set_flags (in_set_flags),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .rf_wr_ready  (rf_wr_ready),
`ifdef WB_BYPASS_EN
    .fwd0_valid   (fwd0_valid),
    .fwd0_rd      (fwd0_rd),
    .fwd0_data    (fwd0_data),
    .fwd1_valid   (fwd1_valid),
    .fwd1_rd      (fwd1_rd),
    .fwd1_data    (fwd1_data),
`endif
    .cpsr         (cpsr)
  );

  typedef struct {
    logic [32:0] res;
    logic        a, b;
    logic [2:0]  oc;
    logic [3:0]  rd;
    logic        we, sf;
  } ent_t;

  ent_t        sb[$];
  ent_t        drv;
  logic [31:0] m_cpsr = 32'd0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] next_cpsr(input ent_t e, input logic [31:0] c);
    logic [31:0] r;
    r     = c;
    r[31] = e.res[31];
    r[30] = (e.res[31:0] == 32'd0);
    if (e.oc == 3'b000) begin
      r[29] = e.res[32];
      r[28] = (e.a == e.b) && (e.res[31] != e.a);
    end else if (e.oc == 3'b001) begin
      r[29] = e.res[32];
      r[28] = (e.a != e.b) && (e.res[31] != e.a);
    end
    return r;
  endfunction

  function automatic ent_t mk(input logic [32:0] res, input logic a, input logic b,
                              input logic [2:0] oc, input logic [3:0] rd,
                              input logic we, input logic sf);
    ent_t e;
    e.res = res; e.a = a; e.b = b; e.oc = oc; e.rd = rd; e.we = we; e.sf = sf;
    return e;
  endfunction

  task automatic drive(input ent_t e);
    drv          = e;
    in_result    = e.res;
    in_op1_msb   = e.a;
    in_op2_msb   = e.b;
    in_alu_oc    = e.oc;
    in_rd        = e.rd;
    in_rd_we     = e.we;
    in_set_flags = e.sf;
  endtask

  // Called just after a falling edge: compare, then advance the model across one rising edge.
  task automatic cycle(output logic acc);
    logic ret;
    ent_t h;
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, sb.size() != 2});
    if (sb.size() > 0 && sb[0].we) begin
      check_eq("rf_wr_en", {31'd0, rf_wr_en}, 32'd1);
      check_eq("rf_wr_addr", {28'd0, rf_wr_addr}, {28'd0, sb[0].rd});
      check_eq("rf_wr_data", rf_wr_data, sb[0].res[31:0]);
    end else begin
      check_eq("rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
    end
    check_eq("cpsr", cpsr, m_cpsr);
    acc = in_valid && (sb.size() != 2);
    ret = 1'b0;
    if (sb.size() > 0) ret = !sb[0].we || rf_wr_ready;
    @(posedge clk);
    if (ret) begin
      h = sb.pop_front();
      if (h.sf) m_cpsr = next_cpsr(h, m_cpsr);
    end
    if (acc) sb.push_back(drv);
    @(negedge clk);
  endtask

  task automatic send(input ent_t e);
    logic acc;
    acc = 1'b0;
    drive(e);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) cycle(acc);
    if (!acc) check_eq("send_timeout", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 50 && sb.size() > 0; i++) idle(1);
    check_eq("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    logic acc;
    // Reset held with a result presented: nothing must get in.
    drive(mk(33'h0_12345678, 1'b0, 1'b0, 3'b000, 4'd9, 1'b1, 1'b1));
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check_eq("rst_cpsr", cpsr, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_wr_addr", {28'd0, rf_wr_addr}, 32'd0);
    check_eq("rst_wr_data", rf_wr_data, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle(1);

    // ADD 0x7FFFFFFF + 1: signed overflow.
    send(mk(33'h0_80000000, 1'b0, 1'b0, 3'b000, 4'd3, 1'b1, 1'b1));
    check_eq("add_wr_en", {31'd0, rf_wr_en}, 32'd1);
    check_eq("add_wr_addr", {28'd0, rf_wr_addr}, 32'd3);
    check_eq("add_wr_data", rf_wr_data, 32'h80000000);
    idle(1);
    check_eq("add_cpsr", cpsr, 32'h90000000);

    // SUB giving zero with carry, no register write.
    send(mk(33'h1_00000000, 1'b0, 1'b0, 3'b001, 4'd4, 1'b0, 1'b1));
    check_eq("sub_wr_en", {31'd0, rf_wr_en}, 32'd0);
    idle(1);
    check_eq("sub_cpsr", cpsr, 32'h60000000);

    // Stall the write port: buffer fills after two accepts.
    rf_wr_ready = 1'b0;
    send(mk(33'h0_00000011, 1'b0, 1'b0, 3'b010, 4'd1, 1'b1, 1'b0));
    send(mk(33'h0_00000022, 1'b0, 1'b0, 3'b010, 4'd2, 1'b1, 1'b0));
    check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
    drive(mk(33'h0_00000033, 1'b0, 1'b0, 3'b010, 4'd8, 1'b1, 1'b0));
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      check_eq("full_no_accept", {31'd0, acc}, 32'd0);
    end
    rf_wr_ready = 1'b1;
    cycle(acc);
    check_eq("ready_back", {31'd0, in_ready}, 32'd1);
    cycle(acc);
    check_eq("third_accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    drain();

    // Logic op after C=1,V=1 keeps C and V.
    send(mk(33'h1_00000000, 1'b1, 1'b1, 3'b000, 4'd5, 1'b1, 1'b1));
    send(mk(33'h0_80000000, 1'b0, 1'b1, 3'b010, 4'd7, 1'b1, 1'b1));
    drain();
    check_eq("logic_cpsr", cpsr, 32'hB0000000);

    // Random traffic with a flaky write port; unaccepted inputs are held.
    acc = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        drive(mk({$urandom_range(0, 1) == 1, 32'($urandom)}, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1))));
      end
      rf_wr_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
    end
    in_valid    = 1'b0;
    rf_wr_ready = 1'b1;
    drain();

    // Reset with two entries buffered.
    rf_wr_ready = 1'b0;
    send(mk(33'h0_00000055, 1'b0, 1'b0, 3'b010, 4'd5, 1'b1, 1'b1));
    send(mk(33'h0_00000066, 1'b0, 1'b0, 3'b010, 4'd6, 1'b1, 1'b1));
`ifdef WB_BYPASS_EN
    check_eq("fwd0_valid", {31'd0, fwd0_valid}, 32'd1);
    check_eq("fwd0_rd", {28'd0, fwd0_rd}, 32'd5);
    check_eq("fwd0_data", fwd0_data, 32'h55);
    check_eq("fwd1_valid", {31'd0, fwd1_valid}, 32'd1);
    check_eq("fwd1_rd", {28'd0, fwd1_rd}, 32'd6);
    check_eq("fwd1_data", fwd1_data, 32'h66);
`endif
    check_eq("pre_rst_wr_en", {31'd0, rf_wr_en}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check_eq("async_rst_cpsr", cpsr, 32'd0);
    check_eq("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    m_cpsr = 32'd0;
    @(negedge clk);
    rst_n       = 1'b1;
    rf_wr_ready = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage directly downstream of the execute stage. Accepts each ALU result with its destination and flag-update control through a valid/ready handshake, and buffers up to two results in a skid buffer so execute can keep issuing while the register-file write port stalls. Retires results in order to the register-file write port. Owns the architectural CPSR and commits N/Z/C/V at retire.

## Interface
- DEPTH, 2: skid-buffer entries (fixed at 2; the parameter exists for assertions only)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute presents a result
- in_ready  out  1  stage can accept; equals (count != 2)
- in_result  in  33  ALU result; bit 32 is carry-out
- in_op1_msb, in_op2_msb  in  1  sign bits of the ALU operands (operand 2 after the immediate/register select)
- in_alu_oc  in  3  ALU opcode
- in_rd  in  4  destination register
- in_rd_we  in  1  result is written to in_rd
- in_set_flags  in  1  instruction updates the CPSR
- rf_wr_en  out  1  register-file write request
- rf_wr_addr  out  4  write address
- rf_wr_data  out  32  write data, in_result[31:0]
- rf_wr_ready  in  1  register file accepts the write this cycle
- cpsr  out  32  bit 31 N, 30 Z, 29 C, 28 V; bits 27:0 always 0

## Operation
- Accept: in_valid && in_ready. Entry {result, msbs, oc, rd, we, sf} is pushed at the FIFO tail.
- Head entry drives the outputs: rf_wr_en = head_valid && head.we; rf_wr_addr and rf_wr_data come from the head.
- Retire: head_valid && (!head.we || rf_wr_ready). A non-writing entry retires in its first head cycle.
- Flags are computed at retire from the head and the current cpsr:
  - N = res[31]
  - Z = (res[31:0] == 0)
  - For ADD: C = res[32]; V = (a == b) && (res[31] != a)
  - For SUB: C = res[32]; V = (a != b) && (res[31] != a)
  - For all other opcodes, C and V keep their previous values.
- cpsr is written only when the retiring entry has sf = 1.
- Simultaneous accept and retire: count is unchanged and order is preserved.
- Accept into an empty buffer: the entry becomes head the next cycle. There is no combinational path from in_* to rf_*.
- in_ready depends only on count, never on rf_wr_ready.

## Timing
- Reset values: count 0, all entries invalid, cpsr 0, rf_wr_en 0, rf_wr_addr 0, rf_wr_data 0. in_ready is 1 while in reset and after release.
- Latency: accept in cycle t puts rf_wr_en high in cycle t+1. The cpsr update is visible in the cycle after retire.
- Throughput: 1 per cycle when rf_wr_ready is held high.
- Full (count 2): in_ready = 0. An in_valid presented while full is ignored and must be held by execute.
- Reset mid-operation clears all buffered entries. Lost writes are not replayed.
- Pointers wrap modulo 2.

## Configuration
- WB_BYPASS_EN defined adds forwarding outputs fwd0_valid, fwd0_rd, fwd0_data (head) and fwd1_valid, fwd1_rd, fwd1_data (tail) for the operand-forwarding mux in front of execute. fwdN_valid = entry valid && entry.we.
- Without WB_BYPASS_EN these ports are absent, and execute must stall on register hazards.

## Structure
- Shared package scc_pkg:
  - ALU opcode constants: ALU_ADD = 3'b000, ALU_SUB = 3'b001
  - CPSR bit indices: CPSR_N = 31, CPSR_Z = 30, CPSR_C = 29, CPSR_V = 28
  - Packed struct wb_entry_t
- Sub-module wb_skid_buf: 2-entry FIFO of wb_entry_t with push, pop and count. wb_stage holds the flag logic and the cpsr register.

## Test plan
- Reset with in_valid = 1 → rf_wr_en = 0, cpsr = 0, in_ready = 1. Release reset, accept ADD of 0x7FFFFFFF + 1 (result 0x0_80000000, sf = 1, we = 1, rd = 3) → next cycle rf_wr_en = 1, addr 3, data 0x80000000; after retire cpsr = 0x90000000 (N, V).
- SUB with result 0x1_00000000, sf = 1, we = 0 → retires without rf_wr_en; cpsr = 0x60000000 (Z, C).
- Hold rf_wr_ready = 0 and push 3 results → in_ready falls after 2 accepts. Release rf_wr_ready → writes occur in order and in_ready returns the cycle after the first retire.
- Logic op with sf = 1 after C = 1, V = 1 → C and V retained; N and Z follow the result.
- Assert rst_n low with 2 entries buffered → buffer empties, rf_wr_en = 0 and cpsr = 0 asynchronously.
- With WB_BYPASS_EN and 2 stalled entries (rd 5, rd 6) → fwd0 = {1, 5, data}, fwd1 = {1, 6, data}.
